ppi_bus_master: RTL and testbench



---
 rtl/ppi_pkg.sv | 40 ++++
 rtl/ppi_bus_master_if.sv | 38 +++
 rtl/ppi_bm_phase_timer.sv | 37 +++
 rtl/ppi_bus_master.sv | 239 +++++++++++++++++++++++
 tb/tb_ppi_bus_master.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/ppi_pkg.sv
// ppi_pkg: shared types and constants for the PPI bus master slice.
//   ppi_bm_state_t    : bus-cycle sequencer states
//   PPI_PORT_*/CTRL   : PPI register addresses
//   PPI_CTRL_RESET    : control word the PPI powers up with (all ports input)
//   PPI_CTRL_MODE_BIT : bit that marks a mode-set word (1) versus a BSR word (0)
package ppi_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } ppi_bm_state_t;

    localparam logic [1:0] PPI_PORT_A = 2'd0;
    localparam logic [1:0] PPI_PORT_B = 2'd1;
    localparam logic [1:0] PPI_PORT_C = 2'd2;
    localparam logic [1:0] PPI_CTRL   = 2'd3;

    localparam logic [7:0] PPI_CTRL_RESET    = 8'h9B;
    localparam int         PPI_CTRL_MODE_BIT = 7;

    // Largest of three phase lengths; sizes the shared phase counter.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) begin
            m = b;
        end else begin
            m = m;
        end
        if (c > m) begin
            m = c;
        end else begin
            m = m;
        end
        return m;
    endfunction

endpackage

// File: rtl/ppi_bus_master_if.sv
// ppi_bus_master_if: request/response handshake plus PPI bus pins.
//   req_*     : one register access offered by the host (valid/ready)
//   rsp_*     : completion pulse and read data back to the host
//   ppi_*     : chip select, strobes, address and split data bus of the PPI
// Modports:
//   master : the bus master block (drives req_ready, rsp_*, PPI control/data out)
//   slave  : the surrounding environment (host requests, PPI data in)
interface ppi_bus_master_if;
    import ppi_pkg::*;

    logic       req_valid;
    logic       req_ready;
    logic       req_wr;
    logic [1:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       ppi_cs;
    logic       ppi_rd;
    logic       ppi_wr;
    logic [1:0] ppi_a;
    logic [7:0] ppi_d_out;
    logic       ppi_d_oe;
    logic [7:0] ppi_d_in;

    modport master (
        input  req_valid, req_wr, req_addr, req_wdata, ppi_d_in,
        output req_ready, rsp_valid, rsp_rdata,
        output ppi_cs, ppi_rd, ppi_wr, ppi_a, ppi_d_out, ppi_d_oe
    );

    modport slave (
        output req_valid, req_wr, req_addr, req_wdata, ppi_d_in,
        input  req_ready, rsp_valid, rsp_rdata,
        input  ppi_cs, ppi_rd, ppi_wr, ppi_a, ppi_d_out, ppi_d_oe
    );

endinterface

// File: rtl/ppi_bm_phase_timer.sv
// ppi_bm_phase_timer: loadable down-counter shared by the SETUP, STROBE and
// HOLD phases. Loaded with (phase length - 1) on phase entry, it counts down
// and parks at zero; tc flags the last cycle of the current phase.
//   clk, reset : clock, synchronous active-high reset (count -> 0)
//   load       : load load_val this edge (takes priority over counting)
//   load_val   : phase length - 1
//   tc         : count is zero
module ppi_bm_phase_timer
    import ppi_pkg::*;
#(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             tc
);

    logic [CNT_W-1:0] count_r;

    // Phase counter: reset, load on phase entry, else count down to zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= {CNT_W{1'b0}};
        end else if (load) begin
            count_r <= load_val;
        end else if (count_r != {CNT_W{1'b0}}) begin
            count_r <= count_r - CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign tc = (count_r == {CNT_W{1'b0}});

endmodule

// File: rtl/ppi_bus_master.sv
// ppi_bus_master: turns one host register access at a time into a PPI bus
// cycle IDLE -> SETUP -> STROBE -> HOLD -> IDLE with programmable phase
// lengths. All PPI-side and response outputs are registered.
//   clk, reset : single clock, synchronous active-high reset
//   bus        : ppi_bus_master_if.master (request, response, PPI pins)
// Parameters SETUP_CYC, STROBE_CYC, HOLD_CYC (each >= 1) set phase lengths.
// Optional build macro PPI_BM_CTRL_SHADOW_EN: keeps a shadow of the last
// mode-set control word and answers control reads from it without a bus cycle.
module ppi_bus_master
    import ppi_pkg::*;
#(
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2,
    parameter int HOLD_CYC   = 1
) (
    input  logic clk,
    input  logic reset,
    ppi_bus_master_if.master bus
);

    localparam int MAX_CYC = max3(SETUP_CYC, STROBE_CYC, HOLD_CYC);
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] SETUP_LOAD  = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] STROBE_LOAD = CNT_W'(STROBE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYC - 1);

    ppi_bm_state_t    state_r;
    ppi_bm_state_t    state_next_s;
    logic             load_s;
    logic [CNT_W-1:0] load_val_s;
    logic             tc_s;
    logic             accept_s;
    logic             rsp_fire_s;
    logic             shadow_rd_s;
    logic             sample_s;
    logic             busy_next_s;
    logic             cur_wr_s;
    logic [1:0]       cur_addr_s;
    logic [7:0]       cur_wdata_s;
    logic [7:0]       shadow_s;

    logic             wr_r;
    logic [1:0]       addr_r;
    logic [7:0]       wdata_r;

    logic             req_ready_r;
    logic             rsp_valid_r;
    logic [7:0]       rsp_rdata_r;
    logic             ppi_cs_r;
    logic             ppi_rd_r;
    logic             ppi_wr_r;
    logic [1:0]       ppi_a_r;
    logic [7:0]       ppi_d_out_r;
    logic             ppi_d_oe_r;

    ppi_bm_phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (load_s),
        .load_val (load_val_s),
        .tc       (tc_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode, phase-counter loads and event strobes.
    always_comb begin
        state_next_s = state_r;
        load_s       = 1'b0;
        load_val_s   = {CNT_W{1'b0}};
        accept_s     = 1'b0;
        rsp_fire_s   = 1'b0;
        shadow_rd_s  = 1'b0;
        sample_s     = 1'b0;
        case (state_r)
            IDLE: begin
                // req_ready is high exactly while in IDLE, so valid alone accepts.
                if (bus.req_valid) begin
                    accept_s = 1'b1;
`ifdef PPI_BM_CTRL_SHADOW_EN
                    if (!bus.req_wr && (bus.req_addr == PPI_CTRL)) begin
                        shadow_rd_s = 1'b1;
                    end else begin
                        state_next_s = SETUP;
                        load_s       = 1'b1;
                        load_val_s   = SETUP_LOAD;
                    end
`else
                    state_next_s = SETUP;
                    load_s       = 1'b1;
                    load_val_s   = SETUP_LOAD;
`endif
                end else begin
                    state_next_s = IDLE;
                end
            end
            SETUP: begin
                if (tc_s) begin
                    state_next_s = STROBE;
                    load_s       = 1'b1;
                    load_val_s   = STROBE_LOAD;
                end else begin
                    state_next_s = SETUP;
                end
            end
            STROBE: begin
                if (tc_s) begin
                    state_next_s = HOLD;
                    load_s       = 1'b1;
                    load_val_s   = HOLD_LOAD;
                    sample_s     = !wr_r;
                end else begin
                    state_next_s = STROBE;
                end
            end
            HOLD: begin
                if (tc_s) begin
                    state_next_s = IDLE;
                    load_s       = 1'b1;
                    load_val_s   = {CNT_W{1'b0}};
                    rsp_fire_s   = 1'b1;
                end else begin
                    state_next_s = HOLD;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Access fields for the coming cycle: fresh request on the accept edge,
    // captured copy otherwise, so outputs register in step with the state.
    always_comb begin
        busy_next_s = (state_next_s != IDLE);
        if (accept_s) begin
            cur_wr_s    = bus.req_wr;
            cur_addr_s  = bus.req_addr;
            cur_wdata_s = bus.req_wdata;
        end else begin
            cur_wr_s    = wr_r;
            cur_addr_s  = addr_r;
            cur_wdata_s = wdata_r;
        end
    end

    // Request capture on accept; held for the rest of the access.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_r    <= 1'b0;
            addr_r  <= 2'd0;
            wdata_r <= 8'h00;
        end else if (accept_s) begin
            wr_r    <= bus.req_wr;
            addr_r  <= bus.req_addr;
            wdata_r <= bus.req_wdata;
        end else begin
            wr_r    <= wr_r;
            addr_r  <= addr_r;
            wdata_r <= wdata_r;
        end
    end

    // Registered PPI outputs; strobes only in STROBE, OE only for writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            req_ready_r <= 1'b1;
            ppi_cs_r    <= 1'b0;
            ppi_rd_r    <= 1'b0;
            ppi_wr_r    <= 1'b0;
            ppi_a_r     <= 2'd0;
            ppi_d_out_r <= 8'h00;
            ppi_d_oe_r  <= 1'b0;
        end else begin
            req_ready_r <= !busy_next_s;
            ppi_cs_r    <= busy_next_s;
            ppi_rd_r    <= (state_next_s == STROBE) && !cur_wr_s;
            ppi_wr_r    <= (state_next_s == STROBE) && cur_wr_s;
            ppi_a_r     <= busy_next_s ? cur_addr_s : 2'd0;
            ppi_d_out_r <= (busy_next_s && cur_wr_s) ? cur_wdata_s : 8'h00;
            ppi_d_oe_r  <= busy_next_s && cur_wr_s;
        end
    end

    // Response: completion pulse and read data held until the next read.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 8'h00;
        end else begin
            rsp_valid_r <= rsp_fire_s || shadow_rd_s;
            if (sample_s) begin
                rsp_rdata_r <= bus.ppi_d_in;
            end else if (shadow_rd_s) begin
                rsp_rdata_r <= shadow_s;
            end else begin
                rsp_rdata_r <= rsp_rdata_r;
            end
        end
    end

`ifdef PPI_BM_CTRL_SHADOW_EN
    logic [7:0] shadow_r;

    // Control shadow: only completed mode-set writes (bit 7 set) update it.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_r <= PPI_CTRL_RESET;
        end else if (rsp_fire_s && wr_r && (addr_r == PPI_CTRL) &&
                     wdata_r[PPI_CTRL_MODE_BIT]) begin
            shadow_r <= wdata_r;
        end else begin
            shadow_r <= shadow_r;
        end
    end

    assign shadow_s = shadow_r;
`else
    assign shadow_s = PPI_CTRL_RESET;
`endif

    assign bus.req_ready = req_ready_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_rdata = rsp_rdata_r;
    assign bus.ppi_cs    = ppi_cs_r;
    assign bus.ppi_rd    = ppi_rd_r;
    assign bus.ppi_wr    = ppi_wr_r;
    assign bus.ppi_a     = ppi_a_r;
    assign bus.ppi_d_out = ppi_d_out_r;
    assign bus.ppi_d_oe  = ppi_d_oe_r;

endmodule

// File: tb/tb_ppi_bus_master.sv
// tb_ppi_bus_master: directed bench for ppi_bus_master. dut0 uses the
// default phase lengths (1/2/1), dut1 uses 3/1/2. Expected waveforms are
// derived from the phase lengths: with accept at edge T0 and cycle k being
// the cycle that ends at edge T0+k, CS is high for k = 1..S+St+H, the strobe
// for k = S+1..S+St, read data is sampled at the edge ending k = S+St and
// rsp_valid is high at k = S+St+H+1.
module tb_ppi_bus_master;
    import ppi_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    ppi_bus_master_if bus0();
    ppi_bus_master_if bus1();

    ppi_bus_master #(.SETUP_CYC(1), .STROBE_CYC(2), .HOLD_CYC(1)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0.master)
    );

    ppi_bus_master #(.SETUP_CYC(3), .STROBE_CYC(1), .HOLD_CYC(2)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1.master)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input int sel, input logic v, input logic wr,
                             input logic [1:0] a, input logic [7:0] wd);
        if (sel == 0) begin
            bus0.req_valid = v; bus0.req_wr = wr; bus0.req_addr = a; bus0.req_wdata = wd;
        end else begin
            bus1.req_valid = v; bus1.req_wr = wr; bus1.req_addr = a; bus1.req_wdata = wd;
        end
    endtask

    // One full bus access on dut<sel>, checked cycle by cycle.
    task automatic run_access(input int sel, input int s, input int st, input int h,
                              input logic wr, input logic [1:0] a, input logic [7:0] wd,
                              input logic [7:0] din, input bit hold_valid, input string nm);
        int n;
        logic cs, rd, wrs, oe, rv, rdy;
        logic [1:0] pa;
        logic [7:0] dout, rdat;
        logic exp_cs, exp_stb;
        n = s + st + h + 1;
        check_eq($sformatf("%s ready", nm), (sel == 0) ? bus0.req_ready : bus1.req_ready, 32'd1);
        drive_req(sel, 1'b1, wr, a, wd);
        tick();
        if (!hold_valid) begin
            drive_req(sel, 1'b0, 1'b0, 2'd0, 8'h00);
        end
        for (int k = 1; k <= n; k++) begin
            if (sel == 0) begin
                bus0.ppi_d_in = (k == s + st) ? din : 8'hEE;
                cs = bus0.ppi_cs; rd = bus0.ppi_rd; wrs = bus0.ppi_wr; oe = bus0.ppi_d_oe;
                pa = bus0.ppi_a; dout = bus0.ppi_d_out; rv = bus0.rsp_valid;
                rdat = bus0.rsp_rdata; rdy = bus0.req_ready;
            end else begin
                bus1.ppi_d_in = (k == s + st) ? din : 8'hEE;
                cs = bus1.ppi_cs; rd = bus1.ppi_rd; wrs = bus1.ppi_wr; oe = bus1.ppi_d_oe;
                pa = bus1.ppi_a; dout = bus1.ppi_d_out; rv = bus1.rsp_valid;
                rdat = bus1.rsp_rdata; rdy = bus1.req_ready;
            end
            exp_cs  = (k <= s + st + h);
            exp_stb = (k > s) && (k <= s + st);
            check_eq($sformatf("%s k%0d cs", nm, k), cs, exp_cs);
            check_eq($sformatf("%s k%0d rd", nm, k), rd, exp_stb && !wr);
            check_eq($sformatf("%s k%0d wr", nm, k), wrs, exp_stb && wr);
            check_eq($sformatf("%s k%0d oe", nm, k), oe, exp_cs && wr);
            check_eq($sformatf("%s k%0d rsp_valid", nm, k), rv, k == n);
            check_eq($sformatf("%s k%0d req_ready", nm, k), rdy, k == n);
            if (exp_cs) begin
                check_eq($sformatf("%s k%0d addr", nm, k), pa, a);
            end
            if (exp_cs && wr) begin
                check_eq($sformatf("%s k%0d dout", nm, k), dout, wd);
            end
            if (k == n && !wr) begin
                check_eq($sformatf("%s rdata", nm), rdat, din);
            end
            if (k < n) begin
                tick();
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        drive_req(0, 1'b0, 1'b0, 2'd0, 8'h00);
        drive_req(1, 1'b0, 1'b0, 2'd0, 8'h00);
        bus0.ppi_d_in = 8'h00;
        bus1.ppi_d_in = 8'h00;
        tick();
        tick();

        // Reset values
        check_eq("rst req_ready", bus0.req_ready, 32'd1);
        check_eq("rst rsp_valid", bus0.rsp_valid, 32'd0);
        check_eq("rst rsp_rdata", bus0.rsp_rdata, 32'h00);
        check_eq("rst cs", bus0.ppi_cs, 32'd0);
        check_eq("rst rd", bus0.ppi_rd, 32'd0);
        check_eq("rst wr", bus0.ppi_wr, 32'd0);
        check_eq("rst a", bus0.ppi_a, 32'd0);
        check_eq("rst dout", bus0.ppi_d_out, 32'h00);
        check_eq("rst oe", bus0.ppi_d_oe, 32'd0);
        check_eq("rst dut1 ready", bus1.req_ready, 32'd1);
        reset = 1'b0;
        tick();

        // Reset in SETUP aborts the access
        drive_req(0, 1'b1, 1'b1, PPI_PORT_A, 8'hF0);
        tick();
        drive_req(0, 1'b0, 1'b0, 2'd0, 8'h00);
        check_eq("abort setup cs", bus0.ppi_cs, 32'd1);
        check_eq("abort setup oe", bus0.ppi_d_oe, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("abort cs", bus0.ppi_cs, 32'd0);
        check_eq("abort wr", bus0.ppi_wr, 32'd0);
        check_eq("abort oe", bus0.ppi_d_oe, 32'd0);
        check_eq("abort ready", bus0.req_ready, 32'd1);
        for (int i = 0; i < 6; i++) begin
            tick();
            check_eq($sformatf("abort c%0d rsp_valid", i), bus0.rsp_valid, 32'd0);
            check_eq($sformatf("abort c%0d cs", i), bus0.ppi_cs, 32'd0);
        end

        // Single write and single read, default timing
        run_access(0, 1, 2, 1, 1'b1, PPI_PORT_A, 8'hF0, 8'h00, 1'b0, "wr_a");
        tick();
        run_access(0, 1, 2, 1, 1'b0, PPI_PORT_B, 8'h00, 8'h3C, 1'b0, "rd_b");
        tick();
        check_eq("rsp_valid one cycle", bus0.rsp_valid, 32'd0);

        // Back-to-back writes with req_valid held
        run_access(0, 1, 2, 1, 1'b1, PPI_PORT_A, 8'hF0, 8'h00, 1'b1, "b2b_a");
        run_access(0, 1, 2, 1, 1'b1, PPI_PORT_B, 8'hCC, 8'h00, 1'b1, "b2b_b");
        run_access(0, 1, 2, 1, 1'b1, PPI_PORT_C, 8'h8A, 8'h00, 1'b0, "b2b_c");
        check_eq("rdata held over writes", bus0.rsp_rdata, 32'h3C);
        tick();

        // Parameter sweep 3/1/2 read
        run_access(1, 3, 1, 2, 1'b0, PPI_PORT_C, 8'h00, 8'h5A, 1'b0, "sweep_rd");
        tick();

        // Control shadow: mode-set write, BSR write, control read
        run_access(0, 1, 2, 1, 1'b1, PPI_CTRL, 8'h80, 8'h00, 1'b0, "ctl_mode");
        tick();
        run_access(0, 1, 2, 1, 1'b1, PPI_CTRL, 8'h0B, 8'h00, 1'b0, "ctl_bsr");
        tick();
`ifdef PPI_BM_CTRL_SHADOW_EN
        check_eq("shadow ready", bus0.req_ready, 32'd1);
        drive_req(0, 1'b1, 1'b0, PPI_CTRL, 8'h00);
        tick();
        drive_req(0, 1'b0, 1'b0, 2'd0, 8'h00);
        check_eq("shadow rsp_valid", bus0.rsp_valid, 32'd1);
        check_eq("shadow rdata", bus0.rsp_rdata, 32'h80);
        check_eq("shadow cs", bus0.ppi_cs, 32'd0);
        check_eq("shadow rd", bus0.ppi_rd, 32'd0);
        tick();
        check_eq("shadow rsp_valid drop", bus0.rsp_valid, 32'd0);
        check_eq("shadow cs after", bus0.ppi_cs, 32'd0);
`else
        run_access(0, 1, 2, 1, 1'b0, PPI_CTRL, 8'h00, 8'h77, 1'b0, "ctl_rd");
`endif
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
